// File: rtl/clk_ratio_detector.sv
// Measures the period and high time of a divided clock sampled in the reference domain.
// Reports each capture with o_valid. Raises o_lock after repeated identical captures and pulses o_timeout when edges stop.
module clk_ratio_detector #(
    parameter int RATIO_WD    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 3
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_meas_clk,
    output logic [RATIO_WD-1:0] o_ratio,
    output logic [RATIO_WD-1:0] o_high_cnt,
    output logic                o_valid,
    output logic                o_lock,
    output logic                o_timeout
);

    localparam logic [RATIO_WD-1:0] CNT_MAX   = {RATIO_WD{1'b1}};
    localparam logic [RATIO_WD-1:0] CNT_ONE   = RATIO_WD'(1);
    localparam logic [2:0]          MATCH_TGT = 3'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE
    } state_t;

    state_t                state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  s_prev;
    logic                  s_cur;
    logic                  rise;

    logic [RATIO_WD-1:0]   per_q, per_d;
    logic [RATIO_WD-1:0]   high_q, high_d;
    logic [2:0]            match_q, match_d;
    logic [RATIO_WD-1:0]   ratio_d, high_out_d;
    logic                  valid_d, lock_d, timeout_d;

    assign s_cur = sync_q[SYNC_STAGES-1];
    assign rise  = s_cur & ~s_prev;

    // The sampling chain runs independently of i_en so the edge history is valid on enable.
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
            // Blocking assignments here would collapse the chain into a single flop.
            sync_q[0] <= i_meas_clk;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_prev <= s_cur;
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            per_q      <= '0;
            high_q     <= '0;
            match_q    <= '0;
            o_ratio    <= '0;
            o_high_cnt <= '0;
            o_valid    <= 1'b0;
            o_lock     <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_q      <= per_d;
            high_q     <= high_d;
            match_q    <= match_d;
            o_ratio    <= ratio_d;
            o_high_cnt <= high_out_d;
            o_valid    <= valid_d;
            o_lock     <= lock_d;
            o_timeout  <= timeout_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is assigned a default first.
        // Without the defaults, a path that skips an assignment would infer a latch.
        state_d    = state_q;
        per_d      = per_q;
        high_d     = high_q;
        match_d    = match_q;
        ratio_d    = o_ratio;
        high_out_d = o_high_cnt;
        valid_d    = 1'b0;
        lock_d     = o_lock;
        timeout_d  = 1'b0;

        if (!i_en) begin
            state_d = IDLE;
            per_d   = '0;
            high_d  = '0;
            match_d = '0;
            lock_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_EDGE;

                WAIT_EDGE: begin
                    if (rise) begin
                        per_d   = CNT_ONE;
                        high_d  = CNT_ONE;
                        state_d = MEASURE;
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        ratio_d    = per_q;
                        high_out_d = high_q;
                        valid_d    = 1'b1;
                        per_d      = CNT_ONE;
                        high_d     = CNT_ONE;
                        // A match count of zero marks the first capture after a fresh edge search.
                        if (match_q != 3'd0 && per_q == o_ratio && high_q == o_high_cnt) begin
                            if (match_q < MATCH_TGT) match_d = match_q + 3'd1;
                        end else begin
                            match_d = 3'd1;
                        end
                        lock_d = (match_d >= MATCH_TGT);
                    end else if (per_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        lock_d    = 1'b0;
                        match_d   = '0;
                        per_d     = '0;
                        high_d    = '0;
                        state_d   = WAIT_EDGE;
                    end else begin
                        per_d = per_q + CNT_ONE;
                        if (s_cur && high_q != CNT_MAX) high_d = high_q + CNT_ONE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_ratio_detector.sv
// Self-checking bench for clk_ratio_detector.
// A reference model works from the recorded input history: rise-edge cycle indices and summed high samples per period.
module tb_clk_ratio_detector;

    localparam int RW    = 4;
    localparam int SS    = 2;
    localparam int LC    = 3;
    localparam int TMAX  = (1 << RW) - 1;

    logic          i_ref_clk = 1'b0;
    logic          i_rst     = 1'b0;
    logic          i_en      = 1'b0;
    logic          i_meas_clk = 1'b0;
    logic [RW-1:0] o_ratio;
    logic [RW-1:0] o_high_cnt;
    logic          o_valid;
    logic          o_lock;
    logic          o_timeout;

    clk_ratio_detector #(
        .RATIO_WD    (RW),
        .SYNC_STAGES (SS),
        .LOCK_CNT    (LC)
    ) dut (
        .i_ref_clk  (i_ref_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_meas_clk (i_meas_clk),
        .o_ratio    (o_ratio),
        .o_high_cnt (o_high_cnt),
        .o_valid    (o_valid),
        .o_lock     (o_lock),
        .o_timeout  (o_timeout)
    );

    always #5 i_ref_clk = ~i_ref_clk;

    int total = 0;
    int bad   = 0;

    // Model state: phase of the measurement, index of the last rising edge, held results.
    typedef enum int {M_IDLE, M_WAIT, M_MEAS} mphase_t;
    bit      hist[$];
    mphase_t m_phase = M_IDLE;
    int      m_last  = 0;
    int      m_ratio = 0;
    int      m_high  = 0;
    int      m_run   = 0;
    bit      m_first = 1'b1;
    bit      m_lock  = 1'b0;
    bit      m_valid = 1'b0;
    bit      m_to    = 1'b0;
    int      valid_seen = 0;
    int      to_seen    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit h(input int i);
        return (i < 0) ? 1'b0 : hist[i];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_phase = M_IDLE;
        m_ratio = 0;
        m_high  = 0;
        m_run   = 0;
        m_first = 1'b1;
        m_lock  = 1'b0;
    endtask

    // One reference cycle: drive at the negedge, advance the model at the posedge, compare at the next negedge.
    task automatic tick(input bit x, input bit e);
        int p, n, hc;
        bit cur, prev, rise;
        i_meas_clk = x;
        i_en       = e;
        hist.push_back(x);
        p = hist.size() - 1;
        @(posedge i_ref_clk);
        cur     = h(p - SS);
        prev    = h(p - SS - 1);
        rise    = cur && !prev;
        m_valid = 1'b0;
        m_to    = 1'b0;
        if (!e) begin
            m_phase = M_IDLE;
            m_lock  = 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: m_phase = M_WAIT;
                M_WAIT: if (rise) begin
                    m_last  = p;
                    m_first = 1'b1;
                    m_phase = M_MEAS;
                end
                default: begin
                    n = p - m_last;
                    if (rise) begin
                        hc = 0;
                        for (int q = m_last; q < p; q++) hc += int'(h(q - SS));
                        if (!m_first && n == m_ratio && hc == m_high) m_run++;
                        else m_run = 1;
                        m_first = 1'b0;
                        m_ratio = n;
                        m_high  = hc;
                        m_lock  = (m_run >= LC);
                        m_valid = 1'b1;
                        m_last  = p;
                    end else if (n == TMAX) begin
                        m_to    = 1'b1;
                        m_lock  = 1'b0;
                        m_phase = M_WAIT;
                    end
                end
            endcase
        end
        @(negedge i_ref_clk);
        check("valid",   32'(o_valid),    32'(m_valid));
        check("timeout", 32'(o_timeout),  32'(m_to));
        check("lock",    32'(o_lock),     32'(m_lock));
        check("ratio",   32'(o_ratio),    32'(m_ratio));
        check("high",    32'(o_high_cnt), 32'(m_high));
        valid_seen += int'(o_valid);
        to_seen    += int'(o_timeout);
    endtask

    // Whole periods of a divided clock: high for the first hi cycles of each period of r cycles.
    task automatic run_div(input int r, input int hi, input int nper, input bit e);
        for (int k = 0; k < r * nper; k++) tick(((k % r) < hi), e);
    endtask

    task automatic run_const(input bit v, input int cycles);
        for (int k = 0; k < cycles; k++) tick(v, 1'b1);
    endtask

    task automatic apply_reset();
        #2 i_rst = 1'b0;
        #1;
        check("rst_ratio",   32'(o_ratio),    32'd0);
        check("rst_high",    32'(o_high_cnt), 32'd0);
        check("rst_valid",   32'(o_valid),    32'd0);
        check("rst_lock",    32'(o_lock),     32'd0);
        check("rst_timeout", 32'(o_timeout),  32'd0);
        @(negedge i_ref_clk);
        @(negedge i_ref_clk);
        i_rst = 1'b1;
        model_reset();
    endtask

    initial begin
        // Power-on reset
        @(negedge i_ref_clk);
        apply_reset();

        // Ratio 4, 2 high
        run_div(4, 2, 10, 1'b1);
        check("r4_ratio", 32'(o_ratio),    32'd4);
        check("r4_high",  32'(o_high_cnt), 32'd2);
        check("r4_lock",  32'(o_lock),     32'd1);

        // Switch to ratio 6, 3 high
        run_div(6, 3, 8, 1'b1);
        check("r6_ratio", 32'(o_ratio),    32'd6);
        check("r6_high",  32'(o_high_cnt), 32'd3);
        check("r6_lock",  32'(o_lock),     32'd1);

        // Back to 4, then bypass (constant input)
        run_div(4, 2, 8, 1'b1);
        to_seen = 0;
        run_const(1'b0, 45);
        check("byp_ratio",  32'(o_ratio), 32'd4);
        check("byp_lock",   32'(o_lock),  32'd0);
        check("byp_pulses", 32'(to_seen), 32'd1);

        // Ratio 5 and 15
        run_div(5, 2, 8, 1'b1);
        check("r5_ratio", 32'(o_ratio),    32'd5);
        check("r5_high",  32'(o_high_cnt), 32'd2);
        check("r5_lock",  32'(o_lock),     32'd1);
        to_seen = 0;
        run_div(15, 7, 6, 1'b1);
        check("r15_ratio", 32'(o_ratio),    32'd15);
        check("r15_high",  32'(o_high_cnt), 32'd7);
        check("r15_lock",  32'(o_lock),     32'd1);
        check("r15_no_to", 32'(to_seen),    32'd0);

        // Enable dropped mid-period, then restored
        run_div(4, 2, 6, 1'b1);
        valid_seen = 0;
        tick(1'b1, 1'b1);
        run_div(4, 2, 2, 1'b0);
        check("en_lock",  32'(o_lock),     32'd0);
        check("en_valid", 32'(valid_seen), 32'd0);
        run_div(4, 2, 10, 1'b1);
        check("en_relock", 32'(o_lock), 32'd1);

        // Reset in the middle of a measurement
        run_div(6, 2, 3, 1'b1);
        tick(1'b1, 1'b1);
        apply_reset();
        run_div(6, 2, 8, 1'b1);
        check("post_rst_ratio", 32'(o_ratio),    32'd6);
        check("post_rst_high",  32'(o_high_cnt), 32'd2);
        check("post_rst_lock",  32'(o_lock),     32'd1);

        // Randomized divider settings, enable drops and noise bursts
        for (int s = 0; s < 30; s++) begin
            int r, hi;
            r  = int'($urandom_range(2, 20));
            hi = int'($urandom_range(1, r - 1));
            run_div(r, hi, int'($urandom_range(2, 6)), ($urandom_range(0, 9) != 0));
            if ($urandom_range(0, 4) == 0) begin
                for (int k = 0; k < 12; k++) tick(1'($urandom_range(0, 1)), 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_ratio_detector.md
Name: clk_ratio_detector

Overview:
- Recovers the division ratio and high time of a divided clock produced from the same reference clock.
- Samples the divided clock as data in the reference domain and measures the reference-cycle distance between its rising edges.
- Reports ratio and high count, a valid strobe, lock after repeated identical measurements, and a timeout when no edges arrive. Bypass mode (ratio 0/1) produces no detectable edges and shows up as timeout.
- Used for divider configuration self-check and clock monitoring in the multi-clock system.

Parameters:
- RATIO_WD, 4, width of ratio and high-count outputs; max measurable period is 2^RATIO_WD-1.
- SYNC_STAGES, 2, number of sampling flops on i_meas_clk (min 1).
- LOCK_CNT, 3, consecutive identical (ratio, high) measurements required to assert lock (range 2..7).

Ports:
- i_ref_clk  input  1  reference clock; sole clock.
- i_rst  input  1  asynchronous active-low reset.
- i_en  input  1  measurement enable.
- i_meas_clk  input  1  divided clock under test, treated as data.
- o_ratio  output  RATIO_WD  last measured period in i_ref_clk cycles.
- o_high_cnt  output  RATIO_WD  high samples within the last measured period.
- o_valid  output  1  one-cycle pulse when o_ratio/o_high_cnt update.
- o_lock  output  1  level; stable measurement established.
- o_timeout  output  1  one-cycle pulse when no rising edge arrives within 2^RATIO_WD-1 cycles.

Behaviour:
- Interface: one clock, i_ref_clk; reset i_rst is asynchronous and active-low.
- Reset: all sync flops, counters, o_ratio, o_high_cnt, o_valid, o_lock, o_timeout = 0; state IDLE.
- Sampling: i_meas_clk passes through SYNC_STAGES flops, giving s_cur. A further flop gives s_prev. rise = s_cur & ~s_prev. The sync chain runs regardless of i_en.
- FSM states: IDLE, WAIT_EDGE, MEASURE.
- IDLE: i_en=1 -> WAIT_EDGE.
- WAIT_EDGE: on rise, per_cnt<=1, high_cnt<=1 -> MEASURE. No timeout in this state.
- MEASURE, cycle without rise: per_cnt+=1; high_cnt+=s_cur.
- MEASURE, cycle with rise: o_ratio<=per_cnt, o_high_cnt<=high_cnt, o_valid=1 on the next cycle. Restart per_cnt<=1, high_cnt<=1; stay in MEASURE.
- Measurement check: with edges at t0 and t0+N, captured ratio = N and high = count of high samples in t0..t0+N-1.
- Timeout: in MEASURE, per_cnt==2^RATIO_WD-1 with no rise -> o_timeout pulse, o_lock<=0, match count cleared, -> WAIT_EDGE. o_ratio and o_high_cnt hold their last values.
- Counters never wrap.
- Lock: a match counter (3 bits) increments on each capture where (per_cnt,high_cnt) equals the currently held (o_ratio,o_high_cnt). It reloads to 1 on a mismatch; a mismatch also drops o_lock in the capture cycle.
- Lock assert: o_lock=1 when the match counter reaches LOCK_CNT-1 further matches, i.e. LOCK_CNT identical consecutive captures. The counter saturates.
- First capture after WAIT_EDGE always counts as mismatch (match=1).
- i_en=0 at any time: next state IDLE; o_lock<=0; counters and match cleared; o_ratio and o_high_cnt held; no o_valid/o_timeout pulse.
- Same-cycle priority: i_en deassert beats rise and timeout. Rise beats timeout.
- Latency: input transition to rise = SYNC_STAGES+1 cycles. Rise to o_valid = 1 cycle.

Test Plan:
- Divided clock ratio 4 (2 high/2 low), i_en=1 -> o_valid every 4 cycles, o_ratio=4, o_high_cnt=2, o_lock=1 after the 3rd valid.
- Ratio 5 (2 high/3 low) -> o_ratio=5, o_high_cnt=2, lock after 3 captures. Ratio 15 (7 high/8 low) -> o_ratio=15, o_high_cnt=7, no timeout.
- Locked at ratio 4, switch to ratio 6 -> first capture o_ratio=6 with o_lock falling that cycle. Relock after 3 captures at 6 with o_high_cnt=3.
- i_meas_clk held constant (bypass) after a lock -> o_timeout pulse 15 cycles after the last rise, o_lock=0, o_ratio still 4. No further pulses until the next rise.
- Drop i_en mid-period, then reassert -> no o_valid for the partial period, o_lock=0. First capture after the next two rises, lock after 3 more.
- Assert i_rst low mid-MEASURE -> all outputs 0 immediately. After release, behaviour matches a fresh start.
